mult_arbiter: RTL and testbench

Round-robin arbiter that shares one `simple_mult` shift-add multiplier between `NUM_REQ` independent requesters, such as the exponentiation and key-generation engines. It latches the winning requester's operands and holds them stable for the whole multiply. It pulses the multiplier start, waits for its result, and returns the product with a one-hot completion strobe. It sits between the requesters and a single multiplier instance, which it drives directly.

---
 rtl/mult_arbiter_pkg.sv | 13 +
 rtl/mult_arbiter_if.sv | 33 +++
 rtl/mult_arbiter_rr_pick.sv | 34 +++
 rtl/mult_arbiter.sv | 108 ++++++++++
 tb/tb_mult_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared types and limits for the round-robin multiplier arbiter.
package mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int MAX_REQ = 8;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier-side signals of mult_arbiter; master is the arbiter,
// slave is whatever surrounds it (requesters plus the multiplier).
interface mult_arbiter_if #(
   parameter int INPUT_SIZE  = 1024,
   parameter int OUTPUT_SIZE = 2 * INPUT_SIZE,
   parameter int NUM_REQ     = 4
);
   logic [NUM_REQ-1:0]            req_in;
   logic [NUM_REQ*INPUT_SIZE-1:0] op_a_in;
   logic [NUM_REQ*INPUT_SIZE-1:0] op_b_in;
   logic [NUM_REQ-1:0]            grant_out;
   logic [NUM_REQ-1:0]            done_out;
   logic [OUTPUT_SIZE-1:0]        result_out;
   logic                          busy_out;
   logic [INPUT_SIZE-1:0]         mult_a_out;
   logic [INPUT_SIZE-1:0]         mult_b_out;
   logic                          mult_start_out;
   logic                          mult_busy_in;
   logic                          mult_valid_in;
   logic [OUTPUT_SIZE-1:0]        mult_result_in;

   modport master (
      input  req_in, op_a_in, op_b_in, mult_busy_in, mult_valid_in, mult_result_in,
      output grant_out, done_out, result_out, busy_out,
             mult_a_out, mult_b_out, mult_start_out
   );

   modport slave (
      output req_in, op_a_in, op_b_in, mult_busy_in, mult_valid_in, mult_result_in,
      input  grant_out, done_out, result_out, busy_out,
             mult_a_out, mult_b_out, mult_start_out
   );
endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request strictly after
// last_grant, wrapping around.
module rr_pick
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // k = NUM_REQ revisits last_grant itself, so it has the lowest priority
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier between NUM_REQ requesters: round-robin pick,
// operand latch, start pulse, result capture and one-hot done strobe.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int INPUT_SIZE  = 1024,
   parameter int OUTPUT_SIZE = 2 * INPUT_SIZE,
   parameter int NUM_REQ     = 4
) (
   input  logic          clk_in,
   input  logic          rst_in,
   mult_arbiter_if.master bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("mult_arbiter: NUM_REQ must be within 2..8");
   end

   arb_state_t             state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [INPUT_SIZE-1:0]  mult_a_q, mult_a_d;
   logic [INPUT_SIZE-1:0]  mult_b_q, mult_b_d;
   logic [OUTPUT_SIZE-1:0] result_q, result_d;
   logic [NUM_REQ-1:0]     pick_grant;
   logic [IDX_W-1:0]       pick_idx;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (bus.req_in),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .idx        (pick_idx)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         grant_idx_q  <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_idx_q  <= grant_idx_d;
         last_grant_q <= last_grant_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         result_q     <= result_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_idx_d  = grant_idx_q;
      last_grant_d = last_grant_q;
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      result_d     = result_q;
      case (state_q)
         IDLE: begin
            // Operands are captured only here; the multiplier re-reads them while iterating
            if (|bus.req_in) begin
               grant_d     = pick_grant;
               grant_idx_d = pick_idx;
               mult_a_d    = bus.op_a_in[pick_idx*INPUT_SIZE +: INPUT_SIZE];
               mult_b_d    = bus.op_b_in[pick_idx*INPUT_SIZE +: INPUT_SIZE];
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.mult_busy_in) state_d = WAIT;
         end
         WAIT: begin
            if (bus.mult_valid_in) begin
               result_d = bus.mult_result_in;
               state_d  = DONE;
            end
         end
         DONE: begin
            last_grant_d = grant_idx_q;
            grant_d      = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.grant_out      = grant_q;
      bus.done_out       = (state_q == DONE) ? grant_q : '0;
      bus.busy_out       = (state_q != IDLE);
      bus.mult_start_out = (state_q == ISSUE) && !bus.mult_busy_in;
      bus.result_out     = result_q;
      bus.mult_a_out     = mult_a_q;
      bus.mult_b_out     = mult_b_q;
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural shift-add multiplier and a
// scoreboard of expected (requester, product) pairs.
module tb_mult_arbiter;

   localparam int IS = 8;
   localparam int OS = 2 * IS;
   localparam int NR = 4;

   typedef struct {
      int idx;
      int prod;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   starts = 0;
   int   pend[NR];
   exp_t sb[$];

   mult_arbiter_if #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .NUM_REQ(NR)) bus ();

   mult_arbiter #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .NUM_REQ(NR)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Shift-add multiplier: one multiplier bit per cycle, stops once the
   // remaining multiplier bits are zero, re-reading input_1 every iteration.
   logic [IS-1:0] m_b;
   logic [OS-1:0] m_acc;
   logic [3:0]    m_sh;

   always @(posedge clk) begin
      if (rst) begin
         bus.mult_busy_in   <= 1'b0;
         bus.mult_valid_in  <= 1'b0;
         bus.mult_result_in <= '0;
         m_b   <= '0;
         m_acc <= '0;
         m_sh  <= '0;
      end else begin
         bus.mult_valid_in <= 1'b0;
         if (!bus.mult_busy_in && bus.mult_start_out) begin
            bus.mult_busy_in <= 1'b1;
            m_b   <= bus.mult_b_out;
            m_acc <= '0;
            m_sh  <= '0;
         end else if (bus.mult_busy_in) begin
            if (m_b == '0) begin
               bus.mult_busy_in   <= 1'b0;
               bus.mult_valid_in  <= 1'b1;
               bus.mult_result_in <= m_acc;
            end else begin
               if (m_b[0]) m_acc <= m_acc + ({{IS{1'b0}}, bus.mult_a_out} << m_sh);
               m_b  <= m_b >> 1;
               m_sh <= m_sh + 4'd1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      bus.op_a_in[i*IS +: IS] = IS'(a);
      bus.op_b_in[i*IS +: IS] = IS'(b);
   endtask

   task automatic request(input int i, input int a, input int b, input int n);
      exp_t e;
      set_ops(i, a, b);
      pend[i] = n;
      for (int k = 0; k < n; k++) begin
         e.idx  = i;
         e.prod = a * b;
         sb.push_back(e);
      end
   endtask

   function automatic int pend_total();
      int s = 0;
      for (int i = 0; i < NR; i++) s += pend[i];
      return s;
   endfunction

   task automatic check_all_zero(input string pfx);
      check({pfx, "_grant"},  bus.grant_out, 0);
      check({pfx, "_done"},   bus.done_out, 0);
      check({pfx, "_start"},  bus.mult_start_out, 0);
      check({pfx, "_busy"},   bus.busy_out, 0);
      check({pfx, "_result"}, bus.result_out, 0);
      check({pfx, "_mult_a"}, bus.mult_a_out, 0);
      check({pfx, "_mult_b"}, bus.mult_b_out, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_in = '0;
      sb.delete();
      for (int i = 0; i < NR; i++) pend[i] = 0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
   endtask

   // Runs until every queued product has been returned, dropping each
   // request right after its final done strobe.
   task automatic run_ops(input int budget);
      exp_t e;
      int   cyc = 0;
      starts = 0;
      while ((pend_total() != 0 || sb.size() != 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus.mult_start_out) starts++;
         if (bus.done_out != '0) begin
            if (sb.size() == 0) begin
               check("done_unexpected", bus.done_out, 0);
            end else begin
               e = sb.pop_front();
               check("done_onehot", bus.done_out, 64'(NR'(1) << e.idx));
               check("result", bus.result_out, 64'(e.prod));
            end
            for (int i = 0; i < NR; i++) begin
               if (bus.done_out[i] && pend[i] > 0) begin
                  pend[i]--;
                  if (pend[i] == 0) bus.req_in[i] = 1'b0;
               end
            end
         end
      end
      if (cyc >= budget) check("timeout_pending", 64'(sb.size() + pend_total()), 0);
      @(negedge clk);
   endtask

   task automatic wait_mult_busy();
      int c = 0;
      while (!bus.mult_busy_in && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (!bus.mult_busy_in) check("mult_busy_wait", bus.mult_busy_in, 1);
   endtask

   initial begin
      bus.req_in  = '0;
      bus.op_a_in = '0;
      bus.op_b_in = '0;
      for (int i = 0; i < NR; i++) pend[i] = 0;

      do_reset();

      // Single request with exactly one start pulse
      request(0, 13, 11, 1);
      bus.req_in[0] = 1'b1;
      run_ops(200);
      check("single_start_cnt", starts, 1);
      check("single_result_hold", bus.result_out, 143);
      check("single_idle_busy", bus.busy_out, 0);

      // All four held from reset: order 0,1,2,3,0
      do_reset();
      request(0, 3, 5, 2);
      request(1, 17, 19, 1);
      request(2, 100, 2, 1);
      request(3, 250, 9, 1);
      sb.delete();
      begin
         exp_t e;
         int order[5] = '{0, 1, 2, 3, 0};
         int prods[NR] = '{15, 323, 200, 2250};
         for (int k = 0; k < 5; k++) begin
            e.idx  = order[k];
            e.prod = prods[order[k]];
            sb.push_back(e);
         end
      end
      bus.req_in = 4'b1111;
      run_ops(400);
      check("rr_start_cnt", starts, 5);

      // Edge operands
      request(1, 255, 255, 1);
      bus.req_in[1] = 1'b1;
      run_ops(200);
      request(1, 255, 0, 1);
      bus.req_in[1] = 1'b1;
      run_ops(200);
      request(2, 0, 200, 1);
      bus.req_in[2] = 1'b1;
      run_ops(200);

      // Operand change while the multiplier iterates
      request(0, 21, 200, 1);
      bus.req_in[0] = 1'b1;
      wait_mult_busy();
      bus.op_a_in[0 +: IS] = 8'd99;
      run_ops(200);
      check("latched_mult_a", bus.mult_a_out, 21);

      // Reset in the middle of WAIT drops the pending operation
      request(0, 200, 255, 1);
      bus.req_in[0] = 1'b1;
      wait_mult_busy();
      check("busy_mid_wait", bus.busy_out, 1);
      rst = 1'b1;
      bus.req_in = '0;
      sb.delete();
      for (int i = 0; i < NR; i++) pend[i] = 0;
      @(negedge clk);
      check_all_zero("midrst");
      rst = 1'b0;
      request(2, 7, 9, 1);
      bus.req_in[2] = 1'b1;
      run_ops(200);

      // Priority rotation: after serving 1, requester 0 wins over 1
      request(1, 6, 7, 1);
      bus.req_in[1] = 1'b1;
      run_ops(200);
      request(0, 11, 12, 1);
      request(1, 13, 14, 1);
      bus.req_in[0] = 1'b1;
      bus.req_in[1] = 1'b1;
      run_ops(300);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
